// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I constants, control encodings and ID/EX record
package rv_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Everything the execute stage needs, captured in one ID/EX record
  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                jump;
    logic                branch;
    logic                alu_src;
    result_src_e         result_src;
    alu_ctl_e            alu_control;
    logic [XLEN-1:0]     rd1;
    logic [XLEN-1:0]     rd2;
    logic [XLEN-1:0]     imm_ext;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
  } idex_t;

  // funct3 to ALU operation; sub_en is only set for R-type with funct7[5]
  function automatic alu_ctl_e alu_decode(input logic [2:0] funct3, input logic sub_en);
    alu_ctl_e op;
    case (funct3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// rtl/decode_cycle_if.sv - IF/ID inputs, write-back port and ID/EX outputs of the decode stage
interface decode_cycle_if;
  import rv_pkg::*;

  logic [XLEN-1:0]   InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RDW;
  logic [XLEN-1:0]   ResultW;
  logic              FlushE;

  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic              ALUSrcE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           RdE, Rs1E, Rs2E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
           ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
           RdE, Rs1E, Rs2E
  );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32x32 register file, 2 async reads, 1 sync write; WB_BYPASS_EN enables write-through
module regfile_2r1w
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs_q [REG_NUM];
  logic [XLEN-1:0] regs_d [REG_NUM];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  // Next register contents: one write per cycle, x0 pinned to zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign rdata1 = (wr_en && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  assign rdata2 = (wr_en && (waddr == raddr2)) ? wdata : regs_q[raddr2];
`else
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];
`endif

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage: control decode, immediates, regfile read, ID/EX register
module decode_cycle
  import rv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_ext;
  imm_src_e        imm_src;
  idex_t           ctl;
  idex_t           idex_d;
  idex_t           idex_q;

  assign instr    = bus.InstrD;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign bus.Rs1D = instr[19:15];
  assign bus.Rs2D = instr[24:20];

  regfile_2r1w u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (instr[19:15]),
    .raddr2 (instr[24:20]),
    .rdata1 (rd1),
    .rdata2 (rd2),
    .we     (bus.RegWriteW),
    .waddr  (bus.RDW),
    .wdata  (bus.ResultW)
  );

  // Opcode to control bits; unknown opcodes decode as a bubble
  always_comb begin
    ctl     = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_LW: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.result_src = RES_MEM;
      end
      OP_SW: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm_src       = IMM_S;
      end
      OP_R: begin
        ctl.reg_write   = 1'b1;
        ctl.alu_control = alu_decode(funct3, instr[30]);
      end
      OP_IALU: begin
        ctl.reg_write   = 1'b1;
        ctl.alu_src     = 1'b1;
        ctl.alu_control = alu_decode(funct3, 1'b0);
      end
      OP_BEQ: begin
        ctl.branch      = 1'b1;
        ctl.alu_control = ALU_SUB;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.jump       = 1'b1;
        ctl.result_src = RES_PC4;
        imm_src        = IMM_J;
      end
      default: ;
    endcase
  end

  // Sign-extended immediate for the selected instruction format
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Next ID/EX contents; a flush loads an all-zero bubble
  always_comb begin
    idex_d          = ctl;
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.imm_ext  = imm_ext;
    idex_d.pc       = bus.PCD;
    idex_d.pc_plus4 = bus.PCPlus4D;
    idex_d.rd       = instr[11:7];
    idex_d.rs1      = instr[19:15];
    idex_d.rs2      = instr[24:20];
    if (bus.FlushE) begin
      idex_d = '0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.RegWriteE   = idex_q.reg_write;
  assign bus.MemWriteE   = idex_q.mem_write;
  assign bus.JumpE       = idex_q.jump;
  assign bus.BranchE     = idex_q.branch;
  assign bus.ALUSrcE     = idex_q.alu_src;
  assign bus.ResultSrcE  = idex_q.result_src;
  assign bus.ALUControlE = idex_q.alu_control;
  assign bus.RD1E        = idex_q.rd1;
  assign bus.RD2E        = idex_q.rd2;
  assign bus.ImmExtE     = idex_q.imm_ext;
  assign bus.PCE         = idex_q.pc;
  assign bus.PCPlus4E    = idex_q.pc_plus4;
  assign bus.RdE         = idex_q.rd;
  assign bus.Rs1E        = idex_q.rs1;
  assign bus.Rs2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed self-checking bench for decode_cycle
module tb_decode_cycle;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.InstrD    = 32'h00500093;
    bus.PCD       = 32'h00000100;
    bus.PCPlus4D  = 32'h00000104;
    bus.RegWriteW = 1'b0;
    bus.RDW       = 5'd0;
    bus.ResultW   = 32'h0;
    bus.FlushE    = 1'b0;

    tick();
    chk("rst_regwrite", {31'b0, bus.RegWriteE}, 32'h0);
    chk("rst_alusrc", {31'b0, bus.ALUSrcE}, 32'h0);
    chk("rst_imm", bus.ImmExtE, 32'h0);
    chk("rst_rd", {27'b0, bus.RdE}, 32'h0);
    chk("rst_pc", bus.PCE, 32'h0);
    chk("rs2d_comb", {27'b0, bus.Rs2D}, 32'd5);

    rst = 1'b1;
    tick();
    chk("addi_regwrite", {31'b0, bus.RegWriteE}, 32'h1);
    chk("addi_alusrc", {31'b0, bus.ALUSrcE}, 32'h1);
    chk("addi_imm", bus.ImmExtE, 32'd5);
    chk("addi_rd", {27'b0, bus.RdE}, 32'd1);
    chk("addi_aluctl", {29'b0, bus.ALUControlE}, 32'h0);
    chk("addi_pc", bus.PCE, 32'h100);
    chk("addi_pc4", bus.PCPlus4E, 32'h104);

    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd3;
    bus.ResultW   = 32'hDEADBEEF;
    bus.InstrD    = 32'h00000000;
    tick();
    chk("bubble_regwrite", {31'b0, bus.RegWriteE}, 32'h0);
    bus.RegWriteW = 1'b0;
    bus.InstrD    = 32'h00018233;
    tick();
    chk("add_rd1", bus.RD1E, 32'hDEADBEEF);
    chk("add_rd2", bus.RD2E, 32'h0);
    chk("add_rde", {27'b0, bus.RdE}, 32'd4);
    chk("add_rs1e", {27'b0, bus.Rs1E}, 32'd3);

    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd0;
    bus.ResultW   = 32'h00001234;
    bus.InstrD    = 32'h00000000;
    tick();
    bus.RegWriteW = 1'b0;
    bus.InstrD    = 32'h000002B3;
    tick();
    chk("x0_read", bus.RD1E, 32'h0);

    bus.InstrD = 32'hFE302E23;
    tick();
    chk("sw_imm", bus.ImmExtE, 32'hFFFFFFFC);
    chk("sw_memwrite", {31'b0, bus.MemWriteE}, 32'h1);
    chk("sw_regwrite", {31'b0, bus.RegWriteE}, 32'h0);
    chk("sw_rd2", bus.RD2E, 32'hDEADBEEF);

    bus.InstrD = 32'hFE000CE3;
    tick();
    chk("beq_imm", bus.ImmExtE, 32'hFFFFFFF8);
    chk("beq_branch", {31'b0, bus.BranchE}, 32'h1);
    chk("beq_aluctl", {29'b0, bus.ALUControlE}, 32'h1);

    bus.InstrD = 32'h001000EF;
    tick();
    chk("jal_imm", bus.ImmExtE, 32'h00000800);
    chk("jal_ressrc", {30'b0, bus.ResultSrcE}, 32'h2);
    chk("jal_jump", {31'b0, bus.JumpE}, 32'h1);
    chk("jal_regwrite", {31'b0, bus.RegWriteE}, 32'h1);

    bus.InstrD = 32'h40000093;
    tick();
    chk("addi_b30_aluctl", {29'b0, bus.ALUControlE}, 32'h0);
    chk("addi_b30_imm", bus.ImmExtE, 32'h00000400);

    bus.InstrD = 32'h40018333;
    tick();
    chk("sub_aluctl", {29'b0, bus.ALUControlE}, 32'h1);
    chk("sub_rd1", bus.RD1E, 32'hDEADBEEF);

    bus.InstrD = 32'h0001F0B3;
    tick();
    chk("and_aluctl", {29'b0, bus.ALUControlE}, 32'h2);

    bus.InstrD = 32'h00302093;
    tick();
    chk("slti_aluctl", {29'b0, bus.ALUControlE}, 32'h5);
    chk("slti_imm", bus.ImmExtE, 32'd3);

    bus.InstrD    = 32'h40018333;
    bus.FlushE    = 1'b1;
    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd7;
    bus.ResultW   = 32'hCAFE0007;
    tick();
    chk("flush_regwrite", {31'b0, bus.RegWriteE}, 32'h0);
    chk("flush_aluctl", {29'b0, bus.ALUControlE}, 32'h0);
    chk("flush_rd1", bus.RD1E, 32'h0);
    chk("flush_rde", {27'b0, bus.RdE}, 32'h0);
    chk("flush_pc", bus.PCE, 32'h0);
    bus.FlushE    = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.InstrD    = 32'h00038433;
    tick();
    chk("flush_wb_landed", bus.RD1E, 32'hCAFE0007);

    bus.RegWriteW = 1'b1;
    bus.RDW       = 5'd5;
    bus.ResultW   = 32'h00000011;
    bus.InstrD    = 32'h00000000;
    tick();
    bus.ResultW   = 32'h00000007;
    bus.InstrD    = 32'h000284B3;
    tick();
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", bus.RD1E, 32'h00000007);
`else
    chk("bypass_rd1", bus.RD1E, 32'h00000011);
`endif
    bus.RegWriteW = 1'b0;
    chk("pre_async_regwrite", {31'b0, bus.RegWriteE}, 32'h1);

    #2;
    rst = 1'b0;
    #1;
    chk("async_regwrite", {31'b0, bus.RegWriteE}, 32'h0);
    chk("async_rd1", bus.RD1E, 32'h0);
    chk("async_rde", {27'b0, bus.RdE}, 32'h0);
    #2;
    rst = 1'b1;
    bus.InstrD = 32'h00018233;
    tick();
    chk("post_rst_x3_cleared", bus.RD1E, 32'h0);
    chk("post_rst_regwrite", {31'b0, bus.RegWriteE}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the 5-stage RV32I pipeline. It takes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D) and decodes the instruction into control signals. It reads the 32x32 register file, writes the register file from the write-back stage, sign-extends immediates, and registers everything into the ID/EX pipeline register feeding the execute stage. Flush control comes from the hazard unit.

## Interface
Parameters:
- none (widths are fixed by shared package constants)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  write-back enable
- RDW  in  5  write-back destination register
- ResultW  in  32  write-back data
- FlushE  in  1  load bubble into ID/EX
- Rs1D, Rs2D  out  5 each  InstrD[19:15], InstrD[24:20], combinational, for the hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered datapath
- RdE, Rs1E, Rs2E  out  5 each  registered register indices

## Operation
- Supported opcodes:
  - lw (0000011): RegWrite=1, ALUSrc=1, ResultSrc=01, ImmSrc I.
  - sw (0100011): MemWrite=1, ALUSrc=1, ImmSrc S.
  - R-type (0110011): RegWrite=1, ALU op from funct3/funct7.
  - I-ALU (0010011): RegWrite=1, ALUSrc=1, ImmSrc I.
  - beq (1100011): Branch=1, ALUControl=sub, ImmSrc B.
  - jal (1101111): RegWrite=1, Jump=1, ResultSrc=10, ImmSrc J.
- ALU decode uses funct3 000/111/110/010 for add/and/or/slt.
  - funct3 000 gives sub only when the opcode is R-type and funct7[5]=1; addi is always add.
- Any other opcode, including 32'h0: every control output 0. The instruction is a bubble.
- Immediate extension, all sign-extended from InstrD[31]:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write on the rising edge when RegWriteW=1 and RDW!=0.
  - Reads are combinational on Rs1D/Rs2D.
- ID/EX register:
  - rst=0: all outputs 0 immediately (async). Register file x1..x31 also clear to 0.
  - FlushE=1: all ID/EX fields load 0 on the next edge. This takes priority over normal load.
  - Otherwise: load decoded values every edge. There is no stall input; the hazard unit stalls upstream and flushes here.

## Timing
- Decode, immediate and register read are combinational within the cycle InstrD is valid. Results appear on the *E outputs one clock later (latency 1).
- Same-cycle write-back and read of the same register: behaviour is set by the macro in Configuration.
- Reset asserted mid-operation clears state instantly, without waiting for clk. The first edge after rst deasserts loads decoded InstrD.
- FlushE and RegWriteW in the same cycle: the register file write still happens; only ID/EX is flushed.

## Configuration
- WB_BYPASS_EN defined: if RegWriteW=1, RDW!=0 and RDW equals Rs1D (or Rs2D), that read port returns ResultW in the same cycle (write-through). This covers the W→D hazard.
- WB_BYPASS_EN undefined: read ports return the stored value only. The hazard unit must stall one extra cycle for a W→D dependency.

## Structure
- Shared package rv_pkg:
  - opcode constants
  - ALUControl, ResultSrc and ImmSrc encodings
  - XLEN=32, REG_AW=5
- Sub-module regfile_2r1w: 2 async read ports, 1 sync write port, x0 hardwired zero, async active-low clear, WB_BYPASS_EN logic.
- Control decode, immediate extension and the ID/EX register sit in decode_cycle.

## Test plan
- Reset: hold rst=0 with InstrD=32'h00500093 → all *E outputs 0. Release, one edge → RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- Write then read: RegWriteW=1, RDW=3, ResultW=32'hDEADBEEF, one edge; then InstrD=add x4,x3,x0 → RD1E=32'hDEADBEEF, RD2E=0 after the next edge.
- x0 protection: RegWriteW=1, RDW=0, ResultW=32'h1234 → a later read of x0 gives RD1E=0.
- Immediates:
  - sw with offset -4 → ImmExtE=32'hFFFFFFFC, MemWriteE=1.
  - beq offset -8 → ImmExtE=32'hFFFFFFF8, BranchE=1, ALUControlE=001.
  - jal offset +2048 → ImmExtE=32'h00000800, ResultSrcE=10.
- FlushE=1 on a valid R-type sub → next edge all *E = 0, while the concurrent W write still lands in the register file.
- Bypass: same-cycle RegWriteW=1, RDW=5, ResultW=7, Rs1D=5:
  - with WB_BYPASS_EN → RD1E=7.
  - without → RD1E equals the old x5 value.
